management_10g_rx_fifo: RTL and testbench
=========================================

# management_10g_rx_fifo

Single-clock frame buffer on the receive side of the 10G management port. It sits in the MAC receive clock domain after the 10G MAC. It accepts an `EthernetRxBus` stream and stores whole frames, discarding them on `drop` or overflow. It presents committed frames (length header plus 32-bit data words) to the downstream clock-crossing stage, which forwards them to the APB/QSPI register interface.

## Interface
- `DEPTH`, 1024: data buffer depth in 32-bit words; power of 2.
- `MAX_FRAMES`, 32: header (frame length) FIFO depth; power of 2.
- `clk`  in  1  receive clock, MAC receive domain.
- `rst`  in  1  reset; synchronous, active high.
- `link_up`  in  1  link status; low flushes all buffered frames.
- `rx_bus`  in  EthernetRxBus  MAC output with fields `start`, `data_valid`, `bytes_valid[2:0]`, `data[31:0]` (first byte in [31:24]), `commit`, `drop`.
- `rd_frame_ready`  out  1  at least one committed frame header is available.
- `rd_frame_len`  out  11  byte length of the head frame; valid while `rd_frame_ready`.
- `rd_frame_pop`  in  1  discard the head header.
- `rd_en`  in  1  read one data word.
- `rd_data`  out  32  data word.
- `rd_valid`  out  1  `rd_data` valid.
- `overflow_count`  out  16  frames discarded for lack of space; saturating.
- `drop_count`  out  16  frames discarded by MAC `drop` or by restart; saturating.

## Operation
- Storage: `DEPTH`x32 RAM; `wr_ptr`, committed `cwr_ptr`, `rd_ptr`, each log2(DEPTH)+1 bits, wrap naturally.
- Free space = `DEPTH - (wr_ptr - rd_ptr)`.
- Write state machine:
  - IDLE: `start` -> `wr_ptr <= cwr_ptr`, `len <= 0`, go to RECEIVING. `data_valid`/`commit`/`drop` are ignored.
  - RECEIVING, `data_valid`:
    - If free space is 0, or `len + bytes_valid > 2047`: `wr_ptr <= cwr_ptr`, `overflow_count++`, go to DISCARD.
    - Otherwise write `data` at `wr_ptr`, `wr_ptr++`, `len += bytes_valid`.
  - RECEIVING, `commit`:
    - Header FIFO not full: push `len`, `cwr_ptr <= wr_ptr` (including any word written in the same cycle), go to IDLE.
    - Header FIFO full: `wr_ptr <= cwr_ptr`, `overflow_count++`, go to IDLE.
  - RECEIVING, `drop`: `wr_ptr <= cwr_ptr`, `drop_count++`, go to IDLE.
  - DISCARD: swallows everything until `commit` or `drop`, then goes to IDLE. No counter change.
  - `start` in RECEIVING (missing commit): abandon the current frame (`drop_count++`), restart as in IDLE.
  - `start` in DISCARD: restart as in IDLE, no count.
  - `commit` and `drop` together: `drop` wins.
- Read side:
  - `rd_en` with `rd_ptr != cwr_ptr`: read RAM at `rd_ptr`, `rd_ptr++`.
  - `rd_en` with `rd_ptr == cwr_ptr`: ignored; `rd_valid` stays 0.
  - Reader must issue ceil(`rd_frame_len`/4) reads per frame, then `rd_frame_pop`.
  - `rd_frame_pop` with no header available: ignored.
- `link_up` low: `wr_ptr`, `cwr_ptr`, `rd_ptr` and header FIFO cleared; state IDLE; counters retained.
- Counters saturate at 16'hffff.

## Timing
- Reset values: all outputs 0; state IDLE; pointers 0; counters 0.
- `rd_data`/`rd_valid`: 1 cycle after `rd_en` (registered RAM output). Back-to-back reads sustain 1 word/cycle.
- `rd_frame_ready` asserts 1 cycle after the cycle carrying accepted `commit`. `rd_frame_len` is valid in the same cycle.
- `rd_frame_pop`: next header (or `rd_frame_ready` = 0) is visible on the following cycle.
- A word written and a word read in the same cycle: the free-space computation uses pre-edge pointers, so it is conservative by one word.
- Pushing header while popping a full header FIFO: the push still counts as full and is rejected (conservative).
- `rst` or `link_up` low mid-frame: frame lost, no counter increment.
- Freed space becomes visible to the write side 1 cycle after the read.

## Test plan
- Single 64-byte frame: `start`, 16 words `bytes_valid`=4, `commit` -> `rd_frame_ready`=1 next cycle, `rd_frame_len`=64; 16 reads return the data in order, 1-cycle latency.
- 61-byte frame, last word `bytes_valid`=1 -> `rd_frame_len`=61; 16 words stored.
- Frame A committed, frame B `drop`ped, frame C committed -> reader sees A then C; `drop_count`=1.
- DEPTH=1024, no reads, three 1500-byte frames -> frames 1 and 2 stored, frame 3 discarded, `overflow_count`=1; after reading and popping frame 1, a new 1500-byte frame is accepted.
- 33 minimal 64-byte frames with no pops -> 32 headers stored, 33rd rejected, `overflow_count`=1, its words not visible.
- `link_up` low mid-frame with 2 frames queued -> `rd_frame_ready`=0, `rd_en` yields no `rd_valid`; the next frame after link restore is stored at a clean state with the correct length.

Source files
------------

// File: rtl/management_10g_rx_fifo_pkg.sv
// rtl/management_10g_rx_fifo_pkg.sv - MAC receive bus type shared by the rx frame FIFO and its bench
package management_10g_rx_fifo_pkg;

   typedef struct packed {
      logic        start;
      logic        data_valid;
      logic [2:0]  bytes_valid;
      logic [31:0] data;
      logic        commit;
      logic        drop;
   } EthernetRxBus;

endpackage

// File: rtl/management_10g_rx_fifo.sv
// rtl/management_10g_rx_fifo.sv - whole-frame receive buffer for the 10G management port
// Frames become readable only once committed; dropped or oversize frames roll back to the committed pointer.
module management_10g_rx_fifo
   import management_10g_rx_fifo_pkg::*;
#(
   parameter int DEPTH      = 1024,
   parameter int MAX_FRAMES = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         link_up,
   input  EthernetRxBus rx_bus,
   output logic         rd_frame_ready,
   output logic [10:0]  rd_frame_len,
   input  logic         rd_frame_pop,
   input  logic         rd_en,
   output logic [31:0]  rd_data,
   output logic         rd_valid,
   output logic [15:0]  overflow_count,
   output logic [15:0]  drop_count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;
   localparam int HAW = $clog2(MAX_FRAMES);
   localparam int HPW = HAW + 1;
   localparam logic [PW-1:0]  DEPTH_P    = PW'(DEPTH);
   localparam logic [HPW-1:0] MAX_FRAMES_P = HPW'(MAX_FRAMES);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DISCARD} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   cwr_ptr_q, cwr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [10:0]     len_q, len_d;
   logic [HPW-1:0]  hdr_wr_q, hdr_wr_d;
   logic [HPW-1:0]  hdr_rd_q, hdr_rd_d;
   logic [15:0]     ovf_cnt_q, ovf_cnt_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic            rd_valid_q, rd_valid_d;
   logic [31:0]     rd_data_q;

   logic [31:0]     mem [DEPTH];
   logic [10:0]     hdr_mem [MAX_FRAMES];

   logic [11:0]     len_sum;
   logic            buf_full;
   logic            hdr_full;
   logic            hdr_avail;
   logic            mem_we;
   logic            hdr_we;
   logic            rd_fire;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hffff) ? v : v + 16'd1;
   endfunction

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      cwr_ptr_d  = cwr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      len_d      = len_q;
      hdr_wr_d   = hdr_wr_q;
      hdr_rd_d   = hdr_rd_q;
      ovf_cnt_d  = ovf_cnt_q;
      drop_cnt_d = drop_cnt_q;
      rd_valid_d = 1'b0;
      mem_we     = 1'b0;
      hdr_we     = 1'b0;
      rd_fire    = 1'b0;

      len_sum   = {1'b0, len_q} + 12'(rx_bus.bytes_valid);
      buf_full  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
      hdr_full  = (hdr_wr_q - hdr_rd_q) == MAX_FRAMES_P;
      hdr_avail = hdr_wr_q != hdr_rd_q;

      if (rd_en && (rd_ptr_q != cwr_ptr_q)) begin
         rd_fire    = 1'b1;
         rd_valid_d = 1'b1;
         rd_ptr_d   = rd_ptr_q + 1'b1;
      end
      if (rd_frame_pop && hdr_avail) begin
         hdr_rd_d = hdr_rd_q + 1'b1;
      end

      if (rx_bus.start) begin
         if (state_q == S_RECV) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
         end
         wr_ptr_d = cwr_ptr_q;
         len_d    = '0;
         state_d  = S_RECV;
      end else begin
         case (state_q)
            S_RECV: begin
               if (rx_bus.drop) begin
                  wr_ptr_d   = cwr_ptr_q;
                  drop_cnt_d = sat_inc(drop_cnt_q);
                  state_d    = S_IDLE;
               end else begin
                  if (rx_bus.data_valid) begin
                     if (buf_full || (len_sum > 12'd2047)) begin
                        wr_ptr_d  = cwr_ptr_q;
                        ovf_cnt_d = sat_inc(ovf_cnt_q);
                        state_d   = rx_bus.commit ? S_IDLE : S_DISCARD;
                     end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        len_d    = len_sum[10:0];
                     end
                  end
                  // A commit in the same cycle as the last word includes that word.
                  if (rx_bus.commit && (state_d == S_RECV)) begin
                     if (!hdr_full) begin
                        hdr_we    = 1'b1;
                        hdr_wr_d  = hdr_wr_q + 1'b1;
                        cwr_ptr_d = wr_ptr_d;
                     end else begin
                        wr_ptr_d  = cwr_ptr_q;
                        ovf_cnt_d = sat_inc(ovf_cnt_q);
                     end
                     state_d = S_IDLE;
                  end
               end
            end
            S_DISCARD: begin
               if (rx_bus.commit || rx_bus.drop) begin
                  state_d = S_IDLE;
               end
            end
            default: ;
         endcase
      end

      if (!link_up) begin
         state_d    = S_IDLE;
         wr_ptr_d   = '0;
         cwr_ptr_d  = '0;
         rd_ptr_d   = '0;
         len_d      = '0;
         hdr_wr_d   = '0;
         hdr_rd_d   = '0;
         ovf_cnt_d  = ovf_cnt_q;
         drop_cnt_d = drop_cnt_q;
         rd_valid_d = 1'b0;
         mem_we     = 1'b0;
         hdr_we     = 1'b0;
         rd_fire    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         cwr_ptr_q  <= '0;
         rd_ptr_q   <= '0;
         len_q      <= '0;
         hdr_wr_q   <= '0;
         hdr_rd_q   <= '0;
         ovf_cnt_q  <= '0;
         drop_cnt_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         cwr_ptr_q  <= cwr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         len_q      <= len_d;
         hdr_wr_q   <= hdr_wr_d;
         hdr_rd_q   <= hdr_rd_d;
         ovf_cnt_q  <= ovf_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr_q[AW-1:0]] <= rx_bus.data;
      end
   end

   always_ff @(posedge clk) begin
      if (hdr_we) begin
         hdr_mem[hdr_wr_q[HAW-1:0]] <= len_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_fire) begin
         rd_data_q <= mem[rd_ptr_q[AW-1:0]];
      end
   end

   // Header RAM is not reset, so the length is masked until a header exists.
   assign rd_frame_ready = hdr_avail;
   assign rd_frame_len   = hdr_avail ? hdr_mem[hdr_rd_q[HAW-1:0]] : 11'd0;
   assign rd_data        = rd_data_q;
   assign rd_valid       = rd_valid_q;
   assign overflow_count = ovf_cnt_q;
   assign drop_count     = drop_cnt_q;

endmodule

// File: tb/tb_management_10g_rx_fifo.sv
// tb/tb_management_10g_rx_fifo.sv - directed bench for the 10G management rx frame FIFO
module tb_management_10g_rx_fifo;
   import management_10g_rx_fifo_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         link_up;
   EthernetRxBus rx_bus;
   logic         rd_frame_ready;
   logic [10:0]  rd_frame_len;
   logic         rd_frame_pop;
   logic         rd_en;
   logic [31:0]  rd_data;
   logic         rd_valid;
   logic [15:0]  overflow_count;
   logic [15:0]  drop_count;

   int tests = 0;
   int fails = 0;
   int exp_ovf = 0;
   int exp_drop = 0;

   always #5 clk = ~clk;

   management_10g_rx_fifo #(.DEPTH(1024), .MAX_FRAMES(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .link_up        (link_up),
      .rx_bus         (rx_bus),
      .rd_frame_ready (rd_frame_ready),
      .rd_frame_len   (rd_frame_len),
      .rd_frame_pop   (rd_frame_pop),
      .rd_en          (rd_en),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .overflow_count (overflow_count),
      .drop_count     (drop_count)
   );

   typedef struct {
      int nbytes;
      bit drop;
      int seed;
      bit exp_stored;
      int exp_len;
   } frame_vec_t;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int seed, input int i);
      return {seed[7:0], 8'ha5, i[15:0]};
   endfunction

   task automatic do_start;
      rx_bus = '0;
      rx_bus.start = 1'b1;
      tick();
      rx_bus = '0;
   endtask

   task automatic send_words(input int nbytes, input int seed);
      int rem;
      rem = nbytes;
      for (int i = 0; rem > 0; i++) begin
         rx_bus = '0;
         rx_bus.data_valid  = 1'b1;
         rx_bus.bytes_valid = (rem >= 4) ? 3'd4 : 3'(rem);
         rx_bus.data        = pat(seed, i);
         rem -= 4;
         tick();
      end
      rx_bus = '0;
   endtask

   task automatic do_end(input bit drop);
      rx_bus = '0;
      rx_bus.commit = ~drop;
      rx_bus.drop   = drop;
      tick();
      rx_bus = '0;
   endtask

   task automatic send_frame(input int nbytes, input int seed, input bit drop);
      do_start();
      send_words(nbytes, seed);
      do_end(drop);
   endtask

   task automatic read_frame(input int len, input int seed, input string tag);
      check({tag, "_ready"}, 32'(rd_frame_ready), 32'd1);
      check({tag, "_len"}, 32'(rd_frame_len), 32'(len));
      for (int i = 0; i < (len + 3) / 4; i++) begin
         rd_en = 1'b1;
         tick();
         check({tag, "_rvalid"}, 32'(rd_valid), 32'd1);
         check({tag, "_rdata"}, rd_data, pat(seed, i));
      end
      rd_en = 1'b0;
      rd_frame_pop = 1'b1;
      tick();
      rd_frame_pop = 1'b0;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_ovf"}, 32'(overflow_count), 32'(exp_ovf));
      check({tag, "_drop"}, 32'(drop_count), 32'(exp_drop));
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_ready0"}, 32'(rd_frame_ready), 32'd0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check({tag, "_novalid"}, 32'(rd_valid), 32'd0);
   endtask

   frame_vec_t vecs[7];

   initial begin
      vecs[0] = '{nbytes: 64,   drop: 1'b0, seed: 1, exp_stored: 1'b1, exp_len: 64};
      vecs[1] = '{nbytes: 61,   drop: 1'b0, seed: 2, exp_stored: 1'b1, exp_len: 61};
      vecs[2] = '{nbytes: 20,   drop: 1'b1, seed: 3, exp_stored: 1'b0, exp_len: 0};
      vecs[3] = '{nbytes: 4,    drop: 1'b0, seed: 4, exp_stored: 1'b1, exp_len: 4};
      vecs[4] = '{nbytes: 2047, drop: 1'b0, seed: 5, exp_stored: 1'b1, exp_len: 2047};
      vecs[5] = '{nbytes: 1,    drop: 1'b0, seed: 6, exp_stored: 1'b1, exp_len: 1};
      vecs[6] = '{nbytes: 7,    drop: 1'b1, seed: 7, exp_stored: 1'b0, exp_len: 0};

      rst = 1'b1;
      link_up = 1'b1;
      rx_bus = '0;
      rd_frame_pop = 1'b0;
      rd_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("rst_ready", 32'(rd_frame_ready), 32'd0);
      check("rst_len", 32'(rd_frame_len), 32'd0);
      check("rst_rvalid", 32'(rd_valid), 32'd0);
      check("rst_rdata", rd_data, 32'd0);
      check_counts("rst");

      check_empty("empty");
      rd_frame_pop = 1'b1;
      tick();
      rd_frame_pop = 1'b0;
      check("empty_pop_ready", 32'(rd_frame_ready), 32'd0);

      // Commit latency: ready must rise exactly one cycle after the commit cycle.
      do_start();
      send_words(64, 9);
      check("single_pre_commit", 32'(rd_frame_ready), 32'd0);
      do_end(1'b0);
      check("single_post_commit", 32'(rd_frame_ready), 32'd1);
      read_frame(64, 9, "single");
      check("single_popped", 32'(rd_frame_ready), 32'd0);

      foreach (vecs[k]) begin
         send_frame(vecs[k].nbytes, vecs[k].seed, vecs[k].drop);
         if (vecs[k].drop) exp_drop++;
      end
      foreach (vecs[k]) begin
         if (vecs[k].exp_stored) read_frame(vecs[k].exp_len, vecs[k].seed, $sformatf("vec%0d", k));
      end
      check_empty("vec_after");
      check_counts("vec");

      // Restart without commit abandons the partial frame.
      do_start();
      send_words(8, 20);
      do_start();
      exp_drop++;
      send_words(12, 21);
      do_end(1'b0);
      read_frame(12, 21, "restart");
      // Commit together with drop: drop wins.
      do_start();
      send_words(8, 22);
      rx_bus.commit = 1'b1;
      rx_bus.drop   = 1'b1;
      tick();
      rx_bus = '0;
      exp_drop++;
      check_empty("commit_drop");
      check_counts("restart");

      // 2048 bytes exceeds the 11-bit length field on the last word.
      send_frame(2048, 23, 1'b0);
      exp_ovf++;
      check_empty("len_ovf");
      check_counts("len_ovf");

      send_frame(1500, 30, 1'b0);
      send_frame(1500, 31, 1'b0);
      send_frame(1500, 32, 1'b0);
      exp_ovf++;
      check_counts("buf_ovf");
      read_frame(1500, 30, "buf_f1");
      send_frame(1500, 33, 1'b0);
      check_counts("buf_refill");
      read_frame(1500, 31, "buf_f2");
      read_frame(1500, 33, "buf_f4");
      check_empty("buf_after");

      // 33rd commit finds the header queue full.
      for (int k = 0; k < 33; k++) send_frame(64, 100 + k, 1'b0);
      exp_ovf++;
      check_counts("hdr_full");
      for (int k = 0; k < 32; k++) read_frame(64, 100 + k, $sformatf("hdr%0d", k));
      check_empty("hdr_after");

      send_frame(64, 50, 1'b0);
      send_frame(64, 51, 1'b0);
      do_start();
      send_words(16, 52);
      link_up = 1'b0;
      tick();
      link_up = 1'b1;
      check_empty("link");
      send_frame(40, 53, 1'b0);
      read_frame(40, 53, "link_new");
      check_empty("link_after");
      check_counts("link");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
